ad9361_capture_ctrl: RTL and testbench



---
 rtl/ad9361_pkg.sv | 15 +
 rtl/ad9361_term_counter.sv | 37 +++
 rtl/ad9361_capture_ctrl.sv | 138 +++++++++++++
 tb/tb_ad9361_capture_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9361_pkg.sv
// Shared definitions for the AD9361 capture path: sequencer state encoding and the
// default AXI burst length, which must match the serializer.
package ad9361_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArmed   = 3'd1,
    StSkip    = 3'd2,
    StCapture = 3'd3,
    StDone    = 3'd4
  } state_e;

  localparam int unsigned DefaultBurstLength = 512;

endpackage

// File: rtl/ad9361_term_counter.sv
// Up-counter with enable, synchronous clear and a compare against a terminal value.
module ad9361_term_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] term_i,
  output logic [Width-1:0] cnt_o,
  output logic             at_term_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Clear has priority so a terminal event can restart the count in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/ad9361_capture_ctrl.sv
// Capture sequencer: gates the four AD9361 channel valids so that exactly N whole
// serializer bursts pass after optional trigger and settling-frame discard.
module ad9361_capture_ctrl
  import ad9361_pkg::*;
#(
  parameter int unsigned AXIS_BURST_LENGTH = DefaultBurstLength,
  parameter int unsigned SKIP_WIDTH        = 16,
  parameter int unsigned BURST_WIDTH       = 16
) (
  input  logic                   data_clk,
  input  logic                   data_rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   trig_en,
  input  logic                   trigger,
  input  logic [SKIP_WIDTH-1:0]  skip_count,
  input  logic [BURST_WIDTH-1:0] burst_count,
  input  logic [3:0]             valid_in,
  output logic [3:0]             valid_out,
  output logic                   busy,
  output logic                   capturing,
  output logic                   done,
  output logic [BURST_WIDTH-1:0] bursts_done
);

  localparam int unsigned SampWidth = $clog2(AXIS_BURST_LENGTH);
  localparam logic [SampWidth-1:0] SampLast = SampWidth'(AXIS_BURST_LENGTH - 1);

  state_e                 state_q, state_d;
  logic [SKIP_WIDTH-1:0]  skip_q;
  logic [BURST_WIDTH-1:0] burst_q;
  logic                   abort_pending_q, abort_pending_d;

  logic                   frame, start_ok;
  logic [SKIP_WIDTH-1:0]  skip_cnt;
  logic [SampWidth-1:0]   samp_cnt;
  logic                   skip_at_term, samp_at_term, burst_at_term;
  logic                   skip_clr, burst_end, last_burst;

  assign frame     = &valid_in;
  assign start_ok  = start & (state_q == StIdle);
  assign skip_clr  = (state_q != StSkip) | (frame & skip_at_term);
  assign burst_end = (state_q == StCapture) & frame & samp_at_term;
  // burst_q == 0 selects continuous mode, where only an abort ends the capture.
  assign last_burst = (burst_q != '0) & burst_at_term;

  ad9361_term_counter #(
    .Width (SKIP_WIDTH)
  ) u_skip_cnt (
    .clk_i     (data_clk),
    .rst_ni    (data_rst_n),
    .en_i      ((state_q == StSkip) & frame),
    .clr_i     (skip_clr),
    .term_i    (skip_q - SKIP_WIDTH'(1)),
    .cnt_o     (skip_cnt),
    .at_term_o (skip_at_term)
  );

  // Burst length is a power of two, so the sample counter wraps on its own at the boundary.
  ad9361_term_counter #(
    .Width (SampWidth)
  ) u_samp_cnt (
    .clk_i     (data_clk),
    .rst_ni    (data_rst_n),
    .en_i      ((state_q == StCapture) & frame),
    .clr_i     (start_ok),
    .term_i    (SampLast),
    .cnt_o     (samp_cnt),
    .at_term_o (samp_at_term)
  );

  ad9361_term_counter #(
    .Width (BURST_WIDTH)
  ) u_burst_cnt (
    .clk_i     (data_clk),
    .rst_ni    (data_rst_n),
    .en_i      (burst_end),
    .clr_i     (start_ok),
    .term_i    (burst_q - BURST_WIDTH'(1)),
    .cnt_o     (bursts_done),
    .at_term_o (burst_at_term)
  );

  logic unused_cnt;
  assign unused_cnt = ^{skip_cnt, samp_cnt};

  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      state_q         <= StIdle;
      skip_q          <= '0;
      burst_q         <= '0;
      abort_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      abort_pending_q <= abort_pending_d;
      if (start_ok) begin
        skip_q  <= skip_count;
        burst_q <= burst_count;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    abort_pending_d = (state_q == StCapture) & (abort_pending_q | abort);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (trig_en)                 state_d = StArmed;
          else if (skip_count != '0)   state_d = StSkip;
          else                         state_d = StCapture;
        end
      end
      StArmed: begin
        if (abort)                     state_d = StIdle;
        else if (trigger)              state_d = (skip_q != '0) ? StSkip : StCapture;
      end
      StSkip: begin
        if (abort)                     state_d = StIdle;
        else if (frame && skip_at_term) state_d = StCapture;
      end
      StCapture: begin
        // An abort on the boundary frame itself still ends at this boundary.
        if (burst_end && (last_burst || abort_pending_q || abort)) state_d = StDone;
      end
      StDone:                          state_d = StIdle;
      default:                         state_d = StIdle;
    endcase
  end

  always_comb begin
    capturing = (state_q == StCapture);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    valid_out = valid_in & {4{capturing}};
  end

endmodule

// File: tb/tb_ad9361_capture_ctrl.sv
// Self-checking bench for ad9361_capture_ctrl against a frame-counting reference model.
module tb_ad9361_capture_ctrl;

  localparam int BL = 512;
  localparam int SW = 16;
  localparam int BW = 16;
  localparam int Budget = 12000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, trig_en = 1'b0, trigger = 1'b0;
  logic [SW-1:0] skip_count = '0;
  logic [BW-1:0] burst_count = '0;
  logic [3:0]    valid_in = '0;
  logic [3:0]    valid_out;
  logic          busy, capturing, done;
  logic [BW-1:0] bursts_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ad9361_capture_ctrl dut (
    .data_clk    (clk),
    .data_rst_n  (rst_n),
    .start       (start),
    .abort       (abort),
    .trig_en     (trig_en),
    .trigger     (trigger),
    .skip_count  (skip_count),
    .burst_count (burst_count),
    .valid_in    (valid_in),
    .valid_out   (valid_out),
    .busy        (busy),
    .capturing   (capturing),
    .done        (done),
    .bursts_done (bursts_done)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    valid_in = 4'hF;
    #1;
    checks++;
    if ({valid_out, busy, capturing, done} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got vo=%h busy=%b cap=%b done=%b, want all 0",
               valid_out, busy, capturing, done);
    end
    checks++;
    if (bursts_done !== '0) begin
      failures++;
      $display("FAIL reset_bursts_done: got %0d, want 0", bursts_done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || valid_out !== 4'h0) begin
      failures++;
      $display("FAIL reset_release_idle: got busy=%b vo=%h, want 0/0", busy, valid_out);
    end
  endtask

  // Model: after arming, the first `skip` full frames are discarded, then valids pass
  // until `target` full frames have passed. An abort during capture rounds the target
  // up to the end of the burst in progress; before capture it returns to idle.
  task automatic test_capture(input string name, input int skip, input int bursts,
                              input bit ten, input int trig_at, input int abort_at,
                              input int vmode, input int start_again_at);
    int          phase;  // 0 waiting trigger, 1 skip/capture, 2 done cycle, 3 idle
    longint      skipped, captured, target, t;
    bit          aborted, cap_exp;
    int          cyc;
    logic [3:0]  v, exp_v;
    logic [BW-1:0] exp_bd;
    skipped = 0; captured = 0; aborted = 0; cyc = 0;
    @(negedge clk);
    start = 1'b1; trig_en = ten; skip_count = SW'(skip); burst_count = BW'(bursts);
    valid_in = 4'hF; abort = 1'b0; trigger = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || valid_out !== 4'h0) begin
      failures++;
      $display("FAIL %s_pre_start: got busy=%b vo=%h, want 0/0", name, busy, valid_out);
    end
    @(negedge clk);
    // Inputs latched on start must not matter afterwards.
    skip_count = SW'($urandom); burst_count = BW'($urandom); trig_en = ~ten;
    phase = ten ? 0 : 1;
    target = (bursts == 0) ? 64'h7FFF_FFFF_FFFF : longint'(bursts) * BL;
    while (phase != 3 && cyc < Budget) begin
      case (vmode)
        0: v = 4'hF;
        1: v = cyc[0] ? 4'hB : 4'hF;
        default: v = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      endcase
      valid_in = v;
      trigger = ten && (cyc == trig_at);
      abort = (cyc == abort_at);
      start = (cyc == start_again_at);
      #1;
      cap_exp = (phase == 1) && (skipped >= skip);
      exp_v = cap_exp ? v : 4'h0;
      exp_bd = BW'(captured / BL);
      checks++;
      if (valid_out !== exp_v) begin
        failures++;
        $display("FAIL %s_valid_out cyc=%0d: got %h, want %h", name, cyc, valid_out, exp_v);
      end
      checks++;
      if (capturing !== cap_exp || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_status cyc=%0d: got cap=%b busy=%b, want cap=%b busy=1",
                 name, cyc, capturing, busy, cap_exp);
      end
      checks++;
      if (done !== (phase == 2)) begin
        failures++;
        $display("FAIL %s_done cyc=%0d: got %b, want %b", name, cyc, done, phase == 2);
      end
      checks++;
      if (bursts_done !== exp_bd) begin
        failures++;
        $display("FAIL %s_bursts_done cyc=%0d: got %0d, want %0d", name, cyc, bursts_done,
                 exp_bd);
      end
      case (phase)
        0: begin
          if (abort) phase = 3;
          else if (trigger) phase = 1;
        end
        1: begin
          if (!cap_exp) begin
            if (abort) phase = 3;
            else if (v == 4'hF) skipped++;
          end else begin
            if (abort && !aborted) begin
              aborted = 1;
              t = (captured / BL + 1) * BL;
              if (t < target) target = t;
            end
            if (v == 4'hF) captured++;
            if (captured == target) phase = 2;
          end
        end
        default: phase = 3;
      endcase
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; abort = 1'b0; trigger = 1'b0; valid_in = 4'h0;
    checks++;
    if (cyc >= Budget) begin
      failures++;
      $display("FAIL %s_timeout: model did not reach idle within %0d cycles", name, Budget);
    end
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bursts_done !== BW'(captured / BL)) begin
      failures++;
      $display("FAIL %s_end: got busy=%b done=%b bd=%0d, want 0/0/%0d", name, busy, done,
               bursts_done, captured / BL);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; trig_en = 1'b0; skip_count = '0; burst_count = '0; valid_in = 4'hF;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    #1;
    checks++;
    if (capturing !== 1'b1 || valid_out !== 4'hF) begin
      failures++;
      $display("FAIL reset_mid_pre: got cap=%b vo=%h, want 1/F", capturing, valid_out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 4'h0 || busy !== 1'b0 || capturing !== 1'b0 || bursts_done !== '0) begin
      failures++;
      $display("FAIL reset_mid_async: got vo=%h busy=%b cap=%b bd=%0d, want 0", valid_out,
               busy, capturing, bursts_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    valid_in = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_abort_idle();
    @(negedge clk);
    abort = 1'b1; valid_in = 4'hF;
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || valid_out !== 4'h0) begin
      failures++;
      $display("FAIL abort_idle: got busy=%b vo=%h, want 0/0", busy, valid_out);
    end
    valid_in = 4'h0;
  endtask

  task automatic test_random();
    int s, b, ab, ta;
    bit te;
    for (int i = 0; i < 4; i++) begin
      s  = $urandom_range(0, 20);
      b  = $urandom_range(0, 3);
      te = 1'($urandom_range(0, 1));
      ta = $urandom_range(0, 30);
      ab = (b == 0) ? $urandom_range(0, 1500) : (($urandom_range(0, 1) != 0) ?
           $urandom_range(0, 1200) : -1);
      test_capture("random", s, b, te, ta, ab, 2, $urandom_range(0, 100));
    end
  endtask

  initial begin
    test_reset();
    test_capture("two_bursts", 0, 2, 1'b0, -1, -1, 0, -1);
    test_capture("skip3", 3, 1, 1'b0, -1, -1, 0, -1);
    test_capture("trigger", 0, 1, 1'b1, 50, -1, 0, -1);
    test_capture("abort_mid", 0, 4, 1'b0, -1, 100, 0, -1);
    test_capture("partial_valid", 0, 1, 1'b0, -1, -1, 1, -1);
    test_capture("abort_last_frame", 0, 3, 1'b0, -1, 511, 0, -1);
    test_capture("continuous_abort", 0, 0, 1'b0, -1, 700, 0, -1);
    test_capture("abort_in_skip", 5, 1, 1'b0, -1, 2, 0, -1);
    test_capture("abort_beats_trigger", 2, 1, 1'b1, 10, 10, 0, -1);
    test_capture("start_while_busy", 1, 1, 1'b0, -1, -1, 0, 20);
    test_reset_mid();
    test_capture("after_reset", 0, 1, 1'b0, -1, -1, 0, -1);
    test_abort_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
